serial_word_receiver: RTL and testbench

//  Receive end of the lab serial link. The shift-register transmitter unloads its word LSB

---
 rtl/serial_word_receiver.sv | 112 +++++++++++
 tb/tb_serial_word_receiver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_receiver.sv
// Serial link receive end: start-bit detect, LSB-first data shift, optional parity, stop check.
// All state advances only on bit_en strobes; the result pulses last exactly one clock.
module serial_word_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  bit_en,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, RECOVER} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  mism_q, mism_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  fe_q, fe_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      dout_q  <= '0;
      mism_q  <= 1'b0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      dout_q  <= dout_d;
      mism_q  <= mism_d;
      dv_q    <= dv_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    dout_d  = dout_q;
    mism_d  = mism_q;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bit_en && !serial_in) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (bit_en) begin
          // Right shift so the first (LSB) bit ends up in sreg[0].
          sreg_d = {serial_in, sreg_q[DATA_WIDTH-1:1]};
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_en) begin
          mism_d  = (((^sreg_q) ^ serial_in) != (PARITY_ODD != 0));
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_en) begin
          if (serial_in) begin
            dout_d  = sreg_q;
            dv_d    = 1'b1;
            pe_d    = (PARITY_EN != 0) && mism_q;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = RECOVER;
          end
        end
      end
      RECOVER: begin
        // Wait for the line to return high so a held-low line cannot fake a start.
        if (bit_en && serial_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out     = dout_q;
  assign data_valid   = dv_q;
  assign parity_error = pe_q;
  assign frame_error  = fe_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: vector table, hand-written corner sequences and random frames
// against a frame-level model, on a no-parity and an even-parity instance.
module tb_serial_word_receiver;

  logic clock = 1'b0;
  logic reset;
  logic be0, si0, be1, si1;
  logic [7:0] data_out0, data_out1;
  logic dv0, pe0, fe0, busy0, dv1, pe1, fe1, busy1;

  always #5 clock = ~clock;

  serial_word_receiver u_np (
    .clock(clock), .reset(reset), .bit_en(be0), .serial_in(si0),
    .data_out(data_out0), .data_valid(dv0), .parity_error(pe0),
    .frame_error(fe0), .busy(busy0)
  );

  serial_word_receiver #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)) u_par (
    .clock(clock), .reset(reset), .bit_en(be1), .serial_in(si1),
    .data_out(data_out1), .data_valid(dv1), .parity_error(pe1),
    .frame_error(fe1), .busy(busy1)
  );

  int total = 0;
  int bad   = 0;

  // Pulse recorders; the test body reads them through size/count snapshots.
  logic [7:0] got0[$];
  logic [8:0] got1[$];
  int fe_cnt0 = 0, fe_cnt1 = 0, stray_pe = 0;

  always @(negedge clock) begin
    if (dv0) got0.push_back(data_out0);
    if (fe0) fe_cnt0++;
    if (dv1) got1.push_back({pe1, data_out1});
    if (fe1) fe_cnt1++;
    if (pe1 && !dv1) stray_pe++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int u, input logic e, input logic s);
    if (u == 0) begin be0 = e; si0 = s; end
    else        begin be1 = e; si1 = s; end
  endtask

  // gap idle cycles with the line driven opposite to the bit, then one strobe.
  task automatic strobe(input int u, input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      drive(u, 1'b0, ~b);
      @(posedge clock); #1;
    end
    drive(u, 1'b1, b);
    @(posedge clock); #1;
    drive(u, 1'b0, 1'b1);
  endtask

  task automatic send(input int u, input logic [7:0] w, input logic par, input logic stop,
                      input int gap);
    strobe(u, 1'b0, gap);
    for (int i = 0; i < 8; i++) strobe(u, w[i], gap);
    if (u == 1) strobe(u, par, gap);
    strobe(u, stop, gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  typedef struct {
    logic [7:0] word;
    logic       stop;
    int         gap;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_fe;
  } vec_t;

  vec_t tbl[6];
  logic [7:0] exp0[$];
  logic [8:0] exp1[$];

  initial begin
    int n0, f0, n1, s1;
    logic [7:0] w;
    logic       p, bd;
    int         ones;

    tbl[0] = '{8'h12, 1'b1, 0, 8'h12, 1, 0};
    tbl[1] = '{8'hFF, 1'b0, 1, 8'h12, 0, 1};
    tbl[2] = '{8'h00, 1'b1, 2, 8'h00, 1, 0};
    tbl[3] = '{8'h80, 1'b1, 3, 8'h80, 1, 0};
    tbl[4] = '{8'h7E, 1'b0, 0, 8'h80, 0, 1};
    tbl[5] = '{8'hC3, 1'b1, 1, 8'hC3, 1, 0};

    reset = 1'b1;
    be0 = 1'b0; si0 = 1'b1; be1 = 1'b0; si1 = 1'b1;
    idle(2);
    chk("rst_data", int'(data_out0), 0);
    chk("rst_valid", int'(dv0), 0);
    chk("rst_ferr", int'(fe0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_perr", int'(pe1), 0);
    reset = 1'b0;
    idle(2);

    // Table of single frames, each followed by one idle-high strobe.
    foreach (tbl[i]) begin
      n0 = got0.size(); f0 = fe_cnt0;
      send(0, tbl[i].word, 1'b0, tbl[i].stop, tbl[i].gap);
      strobe(0, 1'b1, 0);
      idle(2);
      chk($sformatf("tbl%0d_valid", i), got0.size() - n0, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_ferr", i), fe_cnt0 - f0, tbl[i].exp_fe);
      chk($sformatf("tbl%0d_data", i), int'(data_out0), int'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_busy", i), int'(busy0), 0);
    end

    // A5 with a strobe every cycle: valid in the cycle after the stop edge only.
    n0 = got0.size(); f0 = fe_cnt0;
    send(0, 8'hA5, 1'b0, 1'b1, 0);
    chk("a5_valid_now", int'(dv0), 1);
    chk("a5_data_now", int'(data_out0), 8'hA5);
    idle(1);
    chk("a5_valid_clear", int'(dv0), 0);
    idle(2);
    chk("a5_pulses", got0.size() - n0, 1);
    chk("a5_ferr", fe_cnt0 - f0, 0);

    // Same frame with strobes every 4th cycle and the line inverted between strobes.
    n0 = got0.size();
    send(0, 8'hA5, 1'b0, 1'b1, 3);
    idle(2);
    chk("a5gap_pulses", got0.size() - n0, 1);
    chk("a5gap_data", int'(data_out0), 8'hA5);

    // Stop bit 0, then a held-low line, then recovery.
    n0 = got0.size(); f0 = fe_cnt0;
    send(0, 8'h5A, 1'b0, 1'b0, 0);
    chk("stop0_ferr_now", int'(fe0), 1);
    chk("stop0_valid_now", int'(dv0), 0);
    idle(1);
    chk("stop0_ferr_clear", int'(fe0), 0);
    for (int k = 0; k < 5; k++) strobe(0, 1'b0, 1);
    idle(2);
    chk("hold0_busy", int'(busy0), 1);
    chk("hold0_pulses", got0.size() - n0, 0);
    chk("hold0_ferr", fe_cnt0 - f0, 1);
    chk("hold0_data", int'(data_out0), 8'hA5);
    strobe(0, 1'b1, 0);
    chk("recover_busy", int'(busy0), 0);
    strobe(0, 1'b0, 0);
    chk("restart_busy", int'(busy0), 1);
    for (int i = 0; i < 8; i++) strobe(0, 1'(8'h77 >> i), 0);
    strobe(0, 1'b1, 0);
    idle(2);
    chk("restart_pulses", got0.size() - n0, 1);
    chk("restart_data", int'(data_out0), 8'h77);

    // Asynchronous reset after the 4th data bit of FF.
    n0 = got0.size();
    strobe(0, 1'b0, 0);
    for (int i = 0; i < 4; i++) strobe(0, 1'b1, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_data", int'(data_out0), 0);
    chk("arst_busy", int'(busy0), 0);
    chk("arst_valid", int'(dv0), 0);
    #2 reset = 1'b0;
    idle(2);
    send(0, 8'h3C, 1'b0, 1'b1, 0);
    idle(2);
    chk("arst_pulses", got0.size() - n0, 1);
    chk("arst_next_data", int'(data_out0), 8'h3C);

    // Back-to-back frames, no idle strobe between them.
    n0 = got0.size();
    send(0, 8'h01, 1'b0, 1'b1, 0);
    send(0, 8'h80, 1'b0, 1'b1, 0);
    idle(2);
    chk("b2b_pulses", got0.size() - n0, 2);
    if (got0.size() >= n0 + 2) begin
      chk("b2b_first", int'(got0[n0]), 8'h01);
      chk("b2b_second", int'(got0[n0+1]), 8'h80);
    end

    // Even parity instance.
    send(1, 8'h03, 1'b0, 1'b1, 0);
    chk("par_ok_valid", int'(dv1), 1);
    chk("par_ok_perr", int'(pe1), 0);
    chk("par_ok_data", int'(data_out1), 8'h03);
    idle(1);
    send(1, 8'h03, 1'b1, 1'b1, 0);
    chk("par_bad_valid", int'(dv1), 1);
    chk("par_bad_perr", int'(pe1), 1);
    chk("par_bad_data", int'(data_out1), 8'h03);
    idle(1);
    chk("par_bad_clear", int'(pe1), 0);

    // Random frames on the plain instance.
    n0 = got0.size(); f0 = fe_cnt0;
    for (int k = 0; k < 40; k++) begin
      w  = 8'($urandom);
      bd = ($urandom_range(0, 7) == 0);
      send(0, w, 1'b0, ~bd, $urandom_range(0, 3));
      if (bd) strobe(0, 1'b1, $urandom_range(0, 2));
      else begin
        exp0.push_back(w);
        if ($urandom_range(0, 1) == 1) strobe(0, 1'b1, 0);
      end
    end
    idle(3);
    chk("rand0_count", got0.size() - n0, exp0.size());
    chk("rand0_ferr", fe_cnt0 - f0, 40 - exp0.size());
    foreach (exp0[k])
      if (n0 + k < got0.size()) chk($sformatf("rand0_w%0d", k), int'(got0[n0+k]), int'(exp0[k]));

    // Random frames on the parity instance: error when total ones (data + parity) is odd.
    n1 = got1.size(); s1 = stray_pe;
    for (int k = 0; k < 30; k++) begin
      w = 8'($urandom);
      p = 1'($urandom_range(0, 1));
      ones = $countones(w) + int'(p);
      send(1, w, p, 1'b1, $urandom_range(0, 2));
      exp1.push_back({1'((ones % 2) != 0), w});
    end
    idle(3);
    chk("rand1_count", got1.size() - n1, exp1.size());
    chk("rand1_stray_perr", stray_pe - s1, 0);
    chk("rand1_ferr", fe_cnt1, 0);
    foreach (exp1[k])
      if (n1 + k < got1.size()) chk($sformatf("rand1_w%0d", k), int'(got1[n1+k]), int'(exp1[k]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
